pwm: RTL and testbench
======================

PWM -- requirements
Module: pwm

Interface
REQ-001 The block SHALL have parameter XLEN, default 3, which sets the amplitude width; the duty width is XLEN+1.
REQ-002 The block SHALL have port rst, input, 1 bit: the reset; there is one clock, and reset is asynchronous and active-high.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port ampl, input, XLEN bits: high-time in clocks per period, unsigned.
REQ-005 The block SHALL have port duty, input, XLEN+1 bits: period length in clocks, unsigned.
REQ-006 The block SHALL have port signal, output, 1 bit: the registered PWM output.
REQ-007 Port order SHALL be rst, clk, ampl, duty, signal, so positional instantiation works.

Function
REQ-008 The block SHALL hold an internal phase counter cnt, XLEN+1 bits wide, unsigned.
REQ-009 On each rising clk edge with rst low, signal SHALL be loaded with (cnt < ampl), using the pre-edge cnt value; output latency is one clock.
REQ-010 On each rising clk edge with rst low, cnt SHALL load 0 if cnt+1 >= duty, else cnt+1.
REQ-011 The period SHALL be exactly duty clocks when duty >= 1, with signal high for min(ampl, duty) consecutive clocks, then low for the rest.
REQ-012 ampl = 0 SHALL give signal constantly 0.
REQ-013 ampl >= duty SHALL give signal constantly 1 after the first clock.
REQ-014 duty = 0 or duty = 1 SHALL hold cnt at 0, so signal = (ampl != 0) every clock.
REQ-015 Comparisons SHALL zero-extend ampl to XLEN+1 bits.
REQ-016 cnt+1 SHALL be evaluated without overflow (XLEN+2 bits).
REQ-017 Changes to ampl take effect on the next clock edge.
REQ-018 If duty is lowered mid-period so that cnt+1 >= new duty, cnt SHALL wrap to 0 on the next edge; it SHALL never run past duty-1 by more than that one edge.
REQ-019 Inputs SHALL be sampled synchronously only; there is no enable and no handshake.

Reset
REQ-020 While rst is high, cnt SHALL be 0 and signal SHALL be 0, asynchronously and regardless of clk.
REQ-021 On rst deassertion, the first clock edge SHALL start a new period at phase 0, so the first output sample reflects (0 < ampl).
REQ-022 Asserting rst mid-period SHALL abort the period immediately; no partial state survives.

Structure
REQ-023 No shared package SHALL be created; XLEN is the only constant and stays a module parameter.
REQ-024 The phase counter with wrap compare is the natural sub-module, pwm_counter (parameter WIDTH = XLEN+1; outputs cnt).
REQ-025 The output compare register SHALL stay in pwm.
REQ-026 The RTL together with parameter/width assertions SHALL fit within 120-400 lines.

Verification
REQ-027 Reset, ampl=0, duty=7, 9 clocks -> signal 0 on every clock.
REQ-028 Reset, ampl=7, duty=7, 9 clocks -> signal 1 on every clock.
REQ-029 Reset, ampl=4, duty=7, 21 clocks -> signal pattern 1111000 repeated three times, starting on the first clock.
REQ-030 Reset, ampl=2, duty=0, then duty=1, 4 clocks each -> signal constantly 1; ampl=0 with the same duties -> constantly 0.
REQ-031 ampl=3, duty=15 running, duty dropped to 4 while cnt=10 -> cnt wraps to 0 next edge; pattern then settles to 1110 repeating.
REQ-032 rst asserted mid-period between clock edges -> signal and cnt go 0 at once; after release the pattern restarts from phase 0.

Source files
------------

// File: rtl/pwm_counter.sv
// Purpose: phase counter for the PWM; counts 0..duty-1 and wraps, holds at 0 when duty <= 1.
// Latency: cnt reflects a new duty value on the first clock edge after it is presented.
// Backpressure: none; the counter advances on every clock edge.
module pwm_counter #(
  parameter int WIDTH = 4
) (
  input  logic             rst,
  input  logic             clk,
  input  logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  // One extra bit so cnt+1 cannot wrap before it is compared with duty.
  logic [WIDTH:0]   cnt_inc;

  // Next phase: wrap to zero once the incremented phase reaches the period length.
  // Using >= (not ==) also catches duty being lowered below the current phase.
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
    cnt_d   = cnt_inc[WIDTH-1:0];
    if (cnt_inc >= {1'b0, duty}) begin
      cnt_d = '0;
    end
  end

  // Phase register; reset forces phase 0 immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pwm.sv
// Purpose: PWM generator; high for ampl clocks out of every duty clocks.
// Latency: signal is registered, one clock after the phase it reflects.
// Backpressure: none; inputs are sampled every clock, no handshake.
module pwm #(
  parameter int XLEN = 3
) (
  input  logic            rst,
  input  logic            clk,
  input  logic [XLEN-1:0] ampl,
  input  logic [XLEN:0]   duty,
  output logic            signal
);

  localparam int DW = XLEN + 1;

  logic [DW-1:0] cnt;
  logic [DW-1:0] ampl_ext;
  logic          signal_d;
  logic          signal_q;

  pwm_counter #(
    .WIDTH (DW)
  ) u_cnt (
    .rst  (rst),
    .clk  (clk),
    .duty (duty),
    .cnt  (cnt)
  );

  // High while the current phase is still inside the amplitude window.
  always_comb begin
    ampl_ext = {1'b0, ampl};
    signal_d = (cnt < ampl_ext);
  end

  // Output register; reset drives the output low immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signal_q <= 1'b0;
    end else begin
      signal_q <= signal_d;
    end
  end

  assign signal = signal_q;

endmodule

// File: tb/tb_pwm.sv
module tb_pwm;

  logic       rst;
  logic       clk;
  logic [2:0] ampl;
  logic [3:0] duty;
  logic       signal;

  int total;
  int bad;
  bit exp_q[$];
  bit exp_b;

  pwm #(.XLEN(3)) dut (
    .rst    (rst),
    .clk    (clk),
    .ampl   (ampl),
    .duty   (duty),
    .signal (signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  // Queue the expected signal sequence, msb first.
  task automatic push_pattern(input logic [31:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(pat[i]);
  endtask

  // Assert reset away from the clock edge, hold through one edge, release mid-cycle.
  task automatic apply_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ampl = 3'd5; duty = 4'd7;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (signal !== 1'b0) begin
        bad++; $display("FAIL reset_signal: signal=%b expected=0", signal);
      end
      total++;
      if (dut.cnt !== 4'd0) begin
        bad++; $display("FAIL reset_cnt: cnt=%0d expected=0", dut.cnt);
      end
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_ampl_zero();
    apply_reset();
    ampl = 3'd0; duty = 4'd7;
    push_pattern(32'b0, 9);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      exp_b = exp_q.pop_front();
      total++;
      if (signal !== exp_b) begin
        bad++; $display("FAIL ampl_zero clk%0d: signal=%b expected=%b", i, signal, exp_b);
      end
    end
  endtask

  task automatic test_ampl_full();
    apply_reset();
    ampl = 3'd7; duty = 4'd7;
    push_pattern(32'h1ff, 9);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      exp_b = exp_q.pop_front();
      total++;
      if (signal !== exp_b) begin
        bad++; $display("FAIL ampl_full clk%0d: signal=%b expected=%b", i, signal, exp_b);
      end
    end
  endtask

  task automatic test_pattern();
    apply_reset();
    ampl = 3'd4; duty = 4'd7;
    push_pattern(32'b1111000_1111000_1111000, 21);
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      exp_b = exp_q.pop_front();
      total++;
      if (signal !== exp_b) begin
        bad++; $display("FAIL pattern_4_7 clk%0d: signal=%b expected=%b", i, signal, exp_b);
      end
    end
  endtask

  task automatic test_small_duty();
    logic [2:0] amps [2];
    logic       lvl  [2];
    amps[0] = 3'd2; lvl[0] = 1'b1;
    amps[1] = 3'd0; lvl[1] = 1'b0;
    for (int a = 0; a < 2; a++) begin
      apply_reset();
      ampl = amps[a];
      for (int d = 0; d < 2; d++) begin
        duty = 4'(d);
        push_pattern(lvl[a] ? 32'hf : 32'h0, 4);
        for (int i = 0; i < 4; i++) begin
          @(posedge clk); #1;
          exp_b = exp_q.pop_front();
          total++;
          if (signal !== exp_b) begin
            bad++; $display("FAIL small_duty a=%0d d=%0d clk%0d: signal=%b expected=%b",
                            amps[a], d, i, signal, exp_b);
          end
          total++;
          if (dut.cnt !== 4'd0) begin
            bad++; $display("FAIL small_duty_cnt: cnt=%0d expected=0", dut.cnt);
          end
        end
      end
    end
  endtask

  task automatic test_duty_drop();
    apply_reset();
    ampl = 3'd3; duty = 4'd15;
    push_pattern(32'b1110000000, 10);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      exp_b = exp_q.pop_front();
      total++;
      if (signal !== exp_b) begin
        bad++; $display("FAIL duty15 clk%0d: signal=%b expected=%b", i, signal, exp_b);
      end
    end
    total++;
    if (dut.cnt !== 4'd10) begin
      bad++; $display("FAIL drop_precnt: cnt=%0d expected=10", dut.cnt);
    end
    duty = 4'd4;
    // Wrap edge: phase 10 is outside ampl, then phase restarts at 0.
    push_pattern(32'b0_1110_1110_1110, 13);
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        total++;
        if (dut.cnt !== 4'd0) begin
          bad++; $display("FAIL drop_wrap: cnt=%0d expected=0", dut.cnt);
        end
      end
      exp_b = exp_q.pop_front();
      total++;
      if (signal !== exp_b) begin
        bad++; $display("FAIL duty_drop clk%0d: signal=%b expected=%b", i, signal, exp_b);
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    ampl = 3'd4; duty = 4'd7;
    push_pattern(32'b111, 3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      exp_b = exp_q.pop_front();
      total++;
      if (signal !== exp_b) begin
        bad++; $display("FAIL pre_reset clk%0d: signal=%b expected=%b", i, signal, exp_b);
      end
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if (signal !== 1'b0) begin
      bad++; $display("FAIL async_reset_signal: signal=%b expected=0", signal);
    end
    total++;
    if (dut.cnt !== 4'd0) begin
      bad++; $display("FAIL async_reset_cnt: cnt=%0d expected=0", dut.cnt);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    push_pattern(32'b1111000_1111000, 14);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      exp_b = exp_q.pop_front();
      total++;
      if (signal !== exp_b) begin
        bad++; $display("FAIL post_reset clk%0d: signal=%b expected=%b", i, signal, exp_b);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ampl  = '0;
    duty  = '0;
    test_reset();
    test_ampl_zero();
    test_ampl_full();
    test_pattern();
    test_small_duty();
    test_duty_drop();
    test_mid_reset();
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
